regfile_dump_reader: RTL and testbench

Sequential reader for the 32x32 MIPS register file. On a start pulse it walks a configurable address range through the register file's combinational read port and streams each word out over a valid/ready interface. It sits beside the datapath as a debug and observation path, feeding the UART or display blocks. It never writes the register file.

---
 rtl/regfile_dump_reader.sv | 111 +++++++++++
 tb/tb_regfile_dump_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Streams register file words FIRST_REG..LAST_REG over valid/ready; optional XOR checksum beat (DUMP_CHECKSUM_EN).
// Latency: first beat 2 cycles after start, then one beat per 2 cycles with out_ready high.
// Backpressure: beat held stable until out_ready; start ignored while busy.
module regfile_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
    localparam logic [4:0] LAST_A  = 5'(LAST_REG);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, SEND, CSUM} state_t;
    logic [31:0] acc;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

    state_t state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_addr   <= 5'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_index <= 5'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc       <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr <= FIRST_A;
                        busy    <= 1'b1;
                        state   <= LOAD;
`ifdef DUMP_CHECKSUM_EN
                        acc     <= 32'd0;
`endif
                    end
                end
                LOAD: begin
                    // Word is snapshotted here; later regfile writes to this index are not seen.
                    out_data  <= rd_data;
                    out_index <= rd_addr;
                    out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    acc       <= acc ^ rd_data;
`else
                    out_last  <= (rd_addr == LAST_A);
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (rd_addr != LAST_A) begin
                            rd_addr <= rd_addr + 5'd1;
                            state   <= LOAD;
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            state   <= CSUM;
`else
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
`endif
                        end
                    end
                end
`ifdef DUMP_CHECKSUM_EN
                CSUM: begin
                    // First cycle presents the checksum beat, then waits for its handshake.
                    if (!out_valid) begin
                        out_data  <= acc;
                        out_index <= LAST_A;
                        out_last  <= 1'b1;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: regfile model, beat monitor and per-scenario tasks against a queue-based reference.
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0, out_ready = 1'b0;
    logic        start2 = 1'b0, out_ready2 = 1'b1;
    logic [4:0]  rd_addr, rd_addr2, out_index, out_index2;
    logic [31:0] rd_data, rd_data2, out_data, out_data2;
    logic        out_valid, out_last, busy, done;
    logic        out_valid2, out_last2, busy2, done2;
    logic [31:0] regs [32];

    assign rd_data  = regs[rd_addr];
    assign rd_data2 = regs[rd_addr2];

    regfile_dump_reader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    regfile_dump_reader #(.FIRST_REG(29), .LAST_REG(29)) u_single (
        .clk(clk), .rst_n(rst_n), .start(start2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_index(out_index2), .out_last(out_last2), .busy(busy2), .done(done2)
    );

`ifdef DUMP_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    int n_checks = 0, n_pass = 0;
    logic [31:0] got_data [$];
    int          got_idx  [$];
    logic        got_last [$];
    logic [31:0] exp_data [$];
    int          exp_idx  [$];
    logic        exp_last [$];
    int          done_cnt = 0, got2_cnt = 0, done2_cnt = 0;
    logic [31:0] got2_data;
    logic        got2_last;

    // Inputs change just after posedge, so the negedge sees what the next edge will sample.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_idx.push_back(int'(out_index));
                got_last.push_back(out_last);
            end
            if (done) done_cnt++;
            if (out_valid2 && out_ready2) begin
                got2_cnt++;
                got2_data = out_data2;
                got2_last = out_last2;
            end
            if (done2) done2_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_data.delete(); got_idx.delete(); got_last.delete();
        done_cnt = 0;
    endtask

    task automatic load_powerup();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        regs[1] = 32'd1; regs[29] = 32'd256; regs[30] = 32'd256;
    endtask

    // Reference: the dump is the slice of the register file, plus an XOR-folded trailer when enabled.
    task automatic build_expected(input int first, input int last);
        logic [31:0] csum;
        exp_data.delete(); exp_idx.delete(); exp_last.delete();
        csum = 32'd0;
        for (int i = first; i <= last; i++) begin
            exp_data.push_back(regs[i]);
            exp_idx.push_back(i);
            exp_last.push_back(i == last && !CSUM_ON);
            csum = csum ^ regs[i];
        end
        if (CSUM_ON) begin
            exp_data.push_back(csum); exp_idx.push_back(last); exp_last.push_back(1'b1);
        end
    endtask

    task automatic run_dump(input int ready_pct, output int cyc);
        clear_got();
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 1000) begin
            out_ready = ($urandom_range(99) < ready_pct);
            tick();
            cyc++;
        end
        n_checks++; if (!done) $display("FAIL dump_timeout: done=%0b after %0d cycles, need 1", done, cyc); else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b need 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'd0) $display("FAIL reset_data: got %h need 0", out_data); else n_pass++;
        n_checks++; if (out_index !== 5'd0) $display("FAIL reset_index: got %0d need 0", out_index); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b need 0", out_last); else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got %b%b need 00", busy, done); else n_pass++;
        n_checks++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr: got %0d need 0", rd_addr); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_powerup();
        int cyc;
        load_powerup();
        build_expected(0, 31);
        run_dump(100, cyc);
        n_checks++; if (got_data.size() != exp_data.size()) $display("FAIL pwr_count: got %0d need %0d", got_data.size(), exp_data.size()); else n_pass++;
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            n_checks++; if (got_data[i] !== exp_data[i]) $display("FAIL pwr_data[%0d]: got %h need %h", i, got_data[i], exp_data[i]); else n_pass++;
            n_checks++; if (got_idx[i] != exp_idx[i]) $display("FAIL pwr_index[%0d]: got %0d need %0d", i, got_idx[i], exp_idx[i]); else n_pass++;
            n_checks++; if (got_last[i] !== exp_last[i]) $display("FAIL pwr_last[%0d]: got %b need %b", i, got_last[i], exp_last[i]); else n_pass++;
        end
        n_checks++; if (cyc != (CSUM_ON ? 66 : 64)) $display("FAIL pwr_latency: got %0d need %0d", cyc, CSUM_ON ? 66 : 64); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b0 || done_cnt != 1) $display("FAIL pwr_done_pulse: done=%b count=%0d need 0 and 1", done, done_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL pwr_idle_busy: got %b need 0", busy); else n_pass++;
    endtask

    task automatic test_random();
        int cyc;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 32; i++) regs[i] = $urandom;
            build_expected(0, 31);
            run_dump(60, cyc);
            n_checks++; if (got_data.size() != exp_data.size()) $display("FAIL rnd%0d_count: got %0d need %0d", it, got_data.size(), exp_data.size()); else n_pass++;
            for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
                n_checks++; if (got_data[i] !== exp_data[i] || got_idx[i] != exp_idx[i] || got_last[i] !== exp_last[i])
                    $display("FAIL rnd%0d_beat[%0d]: got %h/%0d/%b need %h/%0d/%b", it, i, got_data[i], got_idx[i], got_last[i], exp_data[i], exp_idx[i], exp_last[i]);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        load_powerup();
        build_expected(0, 31);
        clear_got();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_index == 5'd29) && cyc < 200) begin tick(); cyc++; end
        n_checks++; if (!(out_valid && out_index == 5'd29)) $display("FAIL bp_reach29: valid=%b index=%0d need 1/29", out_valid, out_index); else n_pass++;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 32'd256 || out_index !== 5'd29)
                $display("FAIL bp_hold[%0d]: got %b/%h/%0d need 1/00000100/29", k, out_valid, out_data, out_index);
            else n_pass++;
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_accept: valid got %b need 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_index !== 5'd30) $display("FAIL bp_next_beat: got %b/%0d need 1/30", out_valid, out_index); else n_pass++;
        cyc = 0;
        while (!done && cyc < 200) begin tick(); cyc++; end
        n_checks++; if (!done || got_data.size() != exp_data.size()) $display("FAIL bp_complete: done=%b beats=%0d need 1/%0d", done, got_data.size(), exp_data.size()); else n_pass++;
        tick();
    endtask

    task automatic test_single();
        int cyc;
        load_powerup();
        got2_cnt = 0; done2_cnt = 0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 50) begin tick(); cyc++; end
        n_checks++; if (!done2 || cyc != (CSUM_ON ? 4 : 2)) $display("FAIL single_done: done=%b cycles=%0d need 1/%0d", done2, cyc, CSUM_ON ? 4 : 2); else n_pass++;
        n_checks++; if (got2_cnt != (CSUM_ON ? 2 : 1)) $display("FAIL single_count: got %0d need %0d", got2_cnt, CSUM_ON ? 2 : 1); else n_pass++;
        n_checks++; if (got2_data !== 32'd256 || got2_last !== 1'b1) $display("FAIL single_beat: got %h/%b need 00000100/1", got2_data, got2_last); else n_pass++;
        tick();
        n_checks++; if (done2_cnt != 1 || busy2 !== 1'b0) $display("FAIL single_pulse: count=%0d busy=%b need 1/0", done2_cnt, busy2); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        load_powerup();
        build_expected(0, 31);
        clear_got();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            start = (cyc == 20 || cyc == 37);
            tick(); cyc++;
        end
        start = 1'b0;
        n_checks++; if (got_data.size() != exp_data.size()) $display("FAIL b2b_ignored_start: beats %0d need %0d", got_data.size(), exp_data.size()); else n_pass++;
        // done is high now: a start here must begin a fresh dump immediately.
        clear_got();
        start = 1'b1; tick(); start = 1'b0;
        n_checks++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_restart_busy: got %b/%b need 1/0", busy, out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_index !== 5'd0) $display("FAIL b2b_restart_beat: got %b/%0d need 1/0", out_valid, out_index); else n_pass++;
        cyc = 0;
        while (!done && cyc < 200) begin tick(); cyc++; end
        n_checks++; if (!done || got_data.size() != exp_data.size()) $display("FAIL b2b_second_dump: done=%b beats=%0d need 1/%0d", done, got_data.size(), exp_data.size()); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        load_powerup();
        build_expected(0, 31);
        clear_got();
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_index == 5'd10) && cyc < 200) begin tick(); cyc++; end
        out_ready = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_index !== 5'd0 || out_last !== 1'b0)
            $display("FAIL rst_mid_outputs: got %b/%h/%0d/%b need all 0", out_valid, out_data, out_index, out_last);
        else n_pass++;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) $display("FAIL rst_mid_state: got %b/%b/%0d need 0/0/0", busy, done, rd_addr); else n_pass++;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) tick();
        n_checks++; if (done_cnt != 0 || busy !== 1'b0) $display("FAIL rst_mid_no_done: count=%0d busy=%b need 0/0", done_cnt, busy); else n_pass++;
        run_dump(100, cyc);
        n_checks++; if (got_data.size() != exp_data.size() || got_idx[0] != 0) $display("FAIL rst_mid_restart: beats=%0d first=%0d need %0d/0", got_data.size(), got_idx[0], exp_data.size()); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_random();
        test_backpressure();
        test_single();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
